// File: rtl/sr_cmd_gen.sv
// Debounced, edge-triggered set/clear command generator for a downstream SR flop.
// Guarantees s and r are never asserted together and suppresses commands that would not change q.
module sr_cmd_gen #(
    parameter int unsigned DB_CYCLES      = 4,
    parameter int unsigned HOLDOFF_CYCLES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic q_shadow
);

    typedef enum logic [1:0] {IDLE, PULSE, HOLD} state_t;

    localparam logic [7:0] DB_LAST   = 8'(DB_CYCLES - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLDOFF_CYCLES - 1);
    localparam bit         NO_HOLD   = (HOLDOFF_CYCLES == 0);

    // Bit 0 tracks the set line, bit 1 tracks the clear line.
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_db;
    logic [1:0]      r_db_d;
    logic [1:0]      r_edge;
    logic [1:0][7:0] r_cnt;

    state_t     r_state;
    logic [7:0] r_hold_cnt;
    logic       r_pend_vld;
    logic       r_pend_dir;
    logic       r_dir;

    logic w_set_e;
    logic w_clr_e;
    logic w_both;
    logic w_pend_vld;
    logic w_pend_dir;
    logic w_q_now;
    logic w_exit;
    logic w_go;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_d  <= '0;
            r_edge  <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= {clr_req, set_req};
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
            r_edge  <= r_db & ~r_db_d;
            for (int unsigned i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_LAST) begin
                    r_db[i]  <= ~r_db[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign w_set_e = r_edge[0];
    assign w_clr_e = r_edge[1];
    assign w_both  = w_set_e & w_clr_e;

    // Pending slot as it stands after folding in this cycle's edges.
    always_comb begin
        w_pend_vld = r_pend_vld;
        w_pend_dir = r_pend_dir;
        if (w_both) begin
            w_pend_vld = 1'b0;
            w_pend_dir = 1'b0;
        end else if (w_set_e) begin
            w_pend_vld = 1'b1;
            w_pend_dir = 1'b1;
        end else if (w_clr_e) begin
            w_pend_vld = 1'b1;
            w_pend_dir = 1'b0;
        end
    end

    // Leaving PULSE, q_shadow is only just being updated, so judge redundancy against r_dir.
    assign w_q_now = (r_state == PULSE) ? r_dir : q_shadow;
    assign w_exit  = ((r_state == PULSE) && NO_HOLD) ||
                     ((r_state == HOLD) && (r_hold_cnt == HOLD_LAST));
    assign w_go    = w_pend_vld && (w_pend_dir != w_q_now);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_hold_cnt <= '0;
            r_pend_vld <= 1'b0;
            r_pend_dir <= 1'b0;
            r_dir      <= 1'b0;
            s          <= 1'b0;
            r          <= 1'b0;
            busy       <= 1'b0;
            conflict   <= 1'b0;
            q_shadow   <= 1'b0;
        end else begin
            s        <= 1'b0;
            r        <= 1'b0;
            conflict <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_both) begin
                        conflict <= 1'b1;
                    end else if (w_set_e && !q_shadow) begin
                        r_state <= PULSE;
                        r_dir   <= 1'b1;
                        s       <= 1'b1;
                        busy    <= 1'b1;
                    end else if (w_clr_e && q_shadow) begin
                        r_state <= PULSE;
                        r_dir   <= 1'b0;
                        r       <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                PULSE, HOLD: begin
                    conflict <= w_both;
                    if (r_state == PULSE) begin
                        q_shadow <= r_dir;
                    end
                    if (w_exit) begin
                        r_pend_vld <= 1'b0;
                        if (w_go) begin
                            r_state <= PULSE;
                            r_dir   <= w_pend_dir;
                            s       <= w_pend_dir;
                            r       <= ~w_pend_dir;
                            busy    <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end
                    end else begin
                        r_pend_vld <= w_pend_vld;
                        r_pend_dir <= w_pend_dir;
                        r_state    <= HOLD;
                        r_hold_cnt <= (r_state == PULSE) ? '0 : r_hold_cnt + 8'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
